regfile_mp: RTL and testbench

Parametrised, clocked successor to the single-write register file. It provides NUM_RD combinational read ports and one synchronous write port with rd/rt destination select. Reads see a same-cycle write through a write-first bypass, and register 0 is optionally hardwired to zero. A per-register busy scoreboard supports the pipelined datapath: decode reserves a destination and writeback releases it.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 68 ++++++
 rtl/regfile_mp.sv | 70 +++++++
 tb/tb_regfile_mp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file and its busy scoreboard.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: decode reserves a destination, writeback releases it.
// Lookups see a same-cycle release so a consumer is not stalled in the writeback cycle.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int P_ADDR_W   = ADDR_W,
  parameter int P_NUM_RD   = NUM_RD,
  parameter int P_ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         set_en,
  input  logic [P_ADDR_W-1:0]          set_addr,
  input  logic                         clr_en,
  input  logic [P_ADDR_W-1:0]          clr_addr,
  input  logic [P_NUM_RD*P_ADDR_W-1:0] lk_addr,
  output logic [P_NUM_RD-1:0]          lk_busy,
  output logic [P_ADDR_W:0]            busy_cnt
);

  localparam int NREG = 1 << P_ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [P_ADDR_W:0] cnt_q, cnt_d;
  logic set_ok;

  assign set_ok = set_en && !((P_ZERO_REG != 0) && set_addr == '0);

  // A new reservation wins over a completing write to the same register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (set_ok && set_addr == P_ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end else if (clr_en && clr_addr == P_ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + (P_ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

  for (genvar k = 0; k < P_NUM_RD; k++) begin : g_lk
    logic [P_ADDR_W-1:0] a;
    logic rel;
    assign a          = lk_addr[k*P_ADDR_W +: P_ADDR_W];
    assign rel        = clr_en && clr_addr == a && !(set_ok && set_addr == a);
    assign lk_busy[k] = rst_n && busy_q[a] && !rel;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-first bypass, rd/rt destination select,
// optional hardwired zero register and a busy scoreboard for the pipelined datapath.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_RD   = regfile_pkg::NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic                     regdst,
  input  logic [ADDR_W-1:0]        wr_rd,
  input  logic [ADDR_W-1:0]        wr_rt,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int NREG = 1 << ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [ADDR_W-1:0] waddr;
  logic              wr_ok;

  assign waddr = regdst ? wr_rd : wr_rt;
  assign wr_ok = wr_en && !(ZR && waddr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wr_data;
    end
  end

  // Reads are forced to zero while reset is held, even if a write is presented.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];
    assign rd_data[k*DATA_W +: DATA_W] =
      (!rst_n || (ZR && a == '0)) ? '0 :
      (wr_ok && waddr == a)       ? wr_data :
                                    mem_q[a];
  end

  regfile_scoreboard #(
    .P_ADDR_W   (ADDR_W),
    .P_NUM_RD   (NUM_RD),
    .P_ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (alloc_en),
    .set_addr (alloc_addr),
    .clr_en   (wr_en),
    .clr_addr (waddr),
    .lk_addr  (rd_addr),
    .lk_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations come from a small behavioural model.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREG = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic            wr_en, regdst, alloc_en;
  reg_addr_t       wr_rd, wr_rt, alloc_addr;
  reg_data_t       wr_data;
  logic [AW:0]     busy_cnt;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .regdst(regdst), .wr_rd(wr_rd), .wr_rt(wr_rt), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  reg_data_t m_mem [NREG];
  logic      m_busy [NREG];
  int        m_cnt;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] exp;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic reg_addr_t waddr_f();
    return regdst ? wr_rd : wr_rt;
  endfunction

  function automatic reg_data_t exp_data(input reg_addr_t a);
    if (!rst_n || a == 0) return '0;
    if (wr_en && waddr_f() == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input reg_addr_t a);
    logic rel;
    if (!rst_n) return 1'b0;
    rel = wr_en && waddr_f() == a && !(alloc_en && alloc_addr == a && a != 0);
    return m_busy[a] && !rel;
  endfunction

  task automatic expect_now(input string tag);
    reg_addr_t a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      sb_q.push_back('{$sformatf("%s_data%0d", tag, k), k, 64'(exp_data(a))});
      sb_q.push_back('{$sformatf("%s_busy%0d", tag, k), NR + k, 64'(exp_busy(a))});
    end
    sb_q.push_back('{$sformatf("%s_cnt", tag), 2 * NR, 64'(m_cnt)});
  endtask

  task automatic drain();
    exp_t e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sig < NR) obs = 64'(rd_data[e.sig*DW +: DW]);
      else if (e.sig < 2 * NR) obs = 64'(rd_busy[e.sig-NR]);
      else obs = 64'(busy_cnt);
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic checkpoint(input string tag);
    expect_now(tag);
    drain();
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Capture the inputs seen by the edge, advance the model, sample 1ns later.
  task automatic step();
    logic we, ae;
    reg_addr_t wa, aa;
    reg_data_t wd;
    we = wr_en; wa = waddr_f(); wd = wr_data; ae = alloc_en; aa = alloc_addr;
    @(posedge clk);
    if (we && wa != 0) m_mem[wa] = wd;
    if (we) m_busy[wa] = 1'b0;
    if (ae && aa != 0) m_busy[aa] = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < NREG; i++) m_cnt += int'(m_busy[i]);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; regdst = 0; wr_rd = '0; wr_rt = '0; wr_data = '0;
    alloc_en = 0; alloc_addr = '0;
  endtask

  task automatic set_ports(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    model_reset();
    set_ports(5'h05, 5'h1F);
    wr_en = 1; wr_rt = 5'd5; wr_data = 32'hCAFEF00D;
    #2;
    checkpoint("rst");
    chk("rst_data0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);
    @(negedge clk); idle(); rst_n = 1; #1;
    checkpoint("post_rst");
    chk("post_rst_cnt", 64'(busy_cnt), 64'h0);

    // regdst = 1 selects wr_rd
    @(negedge clk);
    wr_en = 1; regdst = 1; wr_rd = 5'd3; wr_rt = 5'd7; wr_data = 32'hDEADBEEF; set_ports(5'd3, 5'd7);
    #1; checkpoint("wr3_pre");
    step();
    @(negedge clk); idle(); set_ports(5'd3, 5'd7); #1;
    checkpoint("wr3");
    chk("reg3", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("reg7", 64'(rd_data[63:32]), 64'h0);

    // regdst = 0 selects wr_rt
    @(negedge clk);
    wr_en = 1; regdst = 0; wr_rd = 5'd3; wr_rt = 5'd7; wr_data = 32'h0BADF00D;
    step();
    @(negedge clk); idle(); #1;
    checkpoint("wr7");
    chk("reg7_rt", 64'(rd_data[63:32]), 64'h0BADF00D);
    chk("reg3_keep", 64'(rd_data[31:0]), 64'hDEADBEEF);

    // write-first bypass
    @(negedge clk);
    set_ports(5'd9, 5'd9); wr_en = 1; regdst = 0; wr_rt = 5'd9; wr_data = 32'h12345678;
    #1;
    chk("byp0", 64'(rd_data[31:0]), 64'h12345678);
    chk("byp1", 64'(rd_data[63:32]), 64'h12345678);
    checkpoint("byp");
    step();
    @(negedge clk); idle(); #1;
    checkpoint("byp_store");
    chk("reg9", 64'(rd_data[31:0]), 64'h12345678);

    // zero register ignores writes and reservations
    @(negedge clk);
    set_ports(5'd0, 5'd4); wr_en = 1; regdst = 1; wr_rd = 5'd0; wr_data = 32'hFFFFFFFF;
    alloc_en = 1; alloc_addr = 5'd0;
    #1;
    chk("zr_data", 64'(rd_data[31:0]), 64'h0);
    checkpoint("zr");
    step();
    chk("zr_cnt", 64'(busy_cnt), 64'h0);
    chk("zr_busy", 64'(rd_busy[0]), 64'h0);
    checkpoint("zr_q");

    // scoreboard: reserve, release bypass, alloc-over-write priority
    @(negedge clk); idle(); alloc_en = 1; alloc_addr = 5'd4; set_ports(5'd4, 5'd4);
    step();
    @(negedge clk); idle(); #1;
    chk("sb_busy", 64'(rd_busy), 64'h3);
    chk("sb_cnt1", 64'(busy_cnt), 64'h1);
    checkpoint("sb_alloc");
    @(negedge clk); wr_en = 1; regdst = 1; wr_rd = 5'd4; wr_data = 32'h44;
    #1;
    chk("sb_rel", 64'(rd_busy), 64'h0);
    chk("sb_rel_cnt", 64'(busy_cnt), 64'h1);
    checkpoint("sb_rel");
    step();
    chk("sb_cnt0", 64'(busy_cnt), 64'h0);
    @(negedge clk); idle(); #1;
    checkpoint("sb_free");
    @(negedge clk); alloc_en = 1; alloc_addr = 5'd4; wr_en = 1; regdst = 1; wr_rd = 5'd4; wr_data = 32'h55;
    #1; checkpoint("sb_both_pre");
    step();
    @(negedge clk); idle(); #1;
    chk("sb_both_busy", 64'(rd_busy), 64'h3);
    chk("sb_both_cnt", 64'(busy_cnt), 64'h1);
    checkpoint("sb_both");

    // asynchronous reset between edges
    @(negedge clk); wr_en = 1; regdst = 0; wr_rt = 5'd2; wr_data = 32'hA5A5A5A5; alloc_en = 1; alloc_addr = 5'd5;
    step();
    @(negedge clk); idle(); alloc_en = 1; alloc_addr = 5'd6;
    step();
    @(negedge clk); idle(); set_ports(5'd2, 5'd5); #1;
    chk("pre_arst_reg2", 64'(rd_data[31:0]), 64'hA5A5A5A5);
    chk("pre_arst_cnt", 64'(busy_cnt), 64'h3);
    checkpoint("pre_arst");
    #1; rst_n = 0; #1;
    model_reset();
    chk("arst_data", 64'(rd_data[31:0]), 64'h0);
    chk("arst_busy", 64'(rd_busy), 64'h0);
    chk("arst_cnt", 64'(busy_cnt), 64'h0);
    checkpoint("arst");
    set_ports(5'd6, 5'd4); #1;
    checkpoint("arst_b");
    rst_n = 1;
    step();
    checkpoint("post_arst");

    // randomized traffic on a small address window to force collisions
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1)); regdst = 1'($urandom_range(0, 1));
      wr_rd = 5'($urandom_range(0, 7)); wr_rt = 5'($urandom_range(0, 7));
      wr_data = $urandom(); alloc_en = 1'($urandom_range(0, 1)); alloc_addr = 5'($urandom_range(0, 7));
      set_ports(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1; checkpoint("rnd");
      step();
      checkpoint("rnd_q");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
